// File: rtl/ascii2int_pkg.sv
// Shared types and constants for the ASCII-to-integer parser.
package ascii2int_pkg;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned ACC_W = 10;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] NINE = 8'h39;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE,
    DISCARD
  } state_e;
endpackage

// File: rtl/ascii2int_digit_decode.sv
// Combinational classifier for a single ASCII character.
module ascii_digit_decode
  import ascii2int_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = CR
) (
  input  logic [7:0] char_i,
  output logic       is_digit_o,
  output logic       is_term_o,
  output logic [3:0] digit_o
);
  assign is_digit_o = (char_i >= ZERO) && (char_i <= NINE);
  assign is_term_o = (char_i == TERM_CHAR) || (char_i == SPACE);
  assign digit_o = char_i[3:0];
endmodule

// File: rtl/ascii2int.sv
// Parses decimal ASCII digits terminated by CR/space into an 8-bit value
// with valid/ready handshakes on both sides.
module ascii2int
  import ascii2int_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3,
  parameter logic [7:0]  TERM_CHAR = CR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         char_in,
  input  logic               char_valid,
  output logic               char_ready,
  output logic [SCORE_W-1:0] value,
  output logic               value_valid,
  input  logic               value_ready,
  output logic               error
);
  localparam logic [1:0] MAXC = 2'(MAX_DIGITS);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] value_q, value_d;
  logic               vv_q, vv_d;
  logic               err_q, err_d;

  logic             is_digit;
  logic             is_term;
  logic [3:0]       digit;
  logic             xfer;
  logic [ACC_W-1:0] acc_nxt;

  ascii_digit_decode #(
    .TERM_CHAR(TERM_CHAR)
  ) u_dec (
    .char_i    (char_in),
    .is_digit_o(is_digit),
    .is_term_o (is_term),
    .digit_o   (digit)
  );

  assign char_ready = (state_q != DONE);
  assign xfer = char_valid && char_ready;
  assign acc_nxt = acc_q * ACC_W'(10) + ACC_W'(digit);

  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    value_d = value_q;
    vv_d = vv_q;
    err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer && is_digit) begin
          acc_d = ACC_W'(digit);
          cnt_d = 2'd1;
          state_d = ACCUM;
        end else if (xfer && !is_term) begin
          err_d = 1'b1;
        end
      end
      ACCUM: begin
        if (xfer) begin
          if (is_digit) begin
            if (cnt_q == MAXC || acc_nxt > ACC_W'(255)) begin
              err_d = 1'b1;
              state_d = DISCARD;
            end else begin
              acc_d = acc_nxt;
              cnt_d = cnt_q + 2'd1;
            end
          end else if (is_term) begin
            value_d = acc_q[SCORE_W-1:0];
            vv_d = 1'b1;
            state_d = DONE;
          end else begin
            err_d = 1'b1;
            state_d = DISCARD;
          end
        end
      end
      DONE: begin
        if (value_ready) begin
          vv_d = 1'b0;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (xfer && is_term) state_d = IDLE;
      end
    endcase
    // Accumulator and count always read zero while idle
    if (state_d == IDLE) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      value_q <= '0;
      vv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      value_q <= value_d;
      vv_q <= vv_d;
      err_q <= err_d;
    end
  end

  assign value = value_q;
  assign value_valid = vv_q;
  assign error = err_q;
endmodule

// File: tb/tb_ascii2int.sv
// Self-checking bench for ascii2int: vector table, corner sequences
// and a randomized stream checked against a token-level model.
module tb_ascii2int;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] value;
  logic       value_valid;
  logic       value_ready = 1'b1;
  logic       error;

  typedef struct {
    string s;
    int    nv;
    int    vl;
    int    ne;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         obs_vals[$];
  int         err_seen = 0;
  bit         rnd_rdy = 1'b0;
  logic [7:0] stream[$];
  int         exp_vals[$];
  int         exp_errs;
  vec_t       tbl[12];

  always #5 clk = ~clk;

  ascii2int #(
    .MAX_DIGITS(3),
    .TERM_CHAR (8'h0D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .value      (value),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .error      (error)
  );

  always @(posedge clk) begin
    if (value_valid && value_ready) obs_vals.push_back(int'(value));
    if (error) err_seen <= err_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) value_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic logic [7:0] map(input byte b);
    return (b == ".") ? 8'h0D : 8'(b);
  endfunction

  task automatic send(input logic [7:0] c);
    int n = 0;
    char_in = c;
    char_valid = 1'b1;
    while (!char_ready && n < 50) begin
      step();
      n++;
    end
    if (!char_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: char_ready=0 required 1");
    end
    step();
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(map(s[i]));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Token-level reference: numbers are runs of digits closed by a terminator
  task automatic model();
    int  digs[$];
    bit  drop;
    int  v;
    logic [7:0] c;
    bit  isd, ist;
    exp_vals = {};
    exp_errs = 0;
    drop = 1'b0;
    foreach (stream[i]) begin
      c = stream[i];
      isd = (c >= 8'h30) && (c <= 8'h39);
      ist = (c == 8'h0D) || (c == 8'h20);
      if (ist) begin
        if (!drop && digs.size() > 0) begin
          v = 0;
          foreach (digs[k]) v = v * 10 + digs[k];
          exp_vals.push_back(v);
        end
        drop = 1'b0;
        digs = {};
      end else if (drop) begin
      end else if (!isd) begin
        exp_errs++;
        if (digs.size() > 0) drop = 1'b1;
      end else begin
        digs.push_back(int'(c) - 48);
        v = 0;
        foreach (digs[k]) v = v * 10 + digs[k];
        if (digs.size() > 3 || v > 255) begin
          exp_errs++;
          drop = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int s0, e0, r;
    logic [7:0] c;

    tbl[0] = '{"42.", 1, 42, 0};
    tbl[1] = '{"256.9.", 1, 9, 1};
    tbl[2] = '{"1234.007.", 1, 7, 1};
    tbl[3] = '{"A1x ", 0, 0, 2};
    tbl[4] = '{"255.", 1, 255, 0};
    tbl[5] = '{"0.", 1, 0, 0};
    tbl[6] = '{" .", 0, 0, 0};
    tbl[7] = '{"99 ", 1, 99, 0};
    tbl[8] = '{"/:.", 0, 0, 2};
    tbl[9] = '{"3x5.12.", 1, 12, 1};
    tbl[10] = '{"300.", 0, 0, 1};
    tbl[11] = '{"1 2.", 2, 2, 0};

    #2 rst = 1'b0;
    #1;
    chk("rst_value", int'(value), 0);
    chk("rst_value_valid", int'(value_valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_char_ready", int'(char_ready), 1);
    step();
    step();
    rst = 1'b1;

    foreach (tbl[i]) begin
      do_reset();
      s0 = obs_vals.size();
      e0 = err_seen;
      send_str(tbl[i].s);
      repeat (4) step();
      chk($sformatf("tbl%0d_count", i), obs_vals.size() - s0, tbl[i].nv);
      if (tbl[i].nv > 0)
        chk($sformatf("tbl%0d_value", i), obs_vals[$], tbl[i].vl);
      chk($sformatf("tbl%0d_errors", i), err_seen - e0, tbl[i].ne);
    end

    // 42 CR: value one cycle after CR, valid for exactly one cycle
    do_reset();
    send_str("42.");
    chk("lat_valid", int'(value_valid), 1);
    chk("lat_value", int'(value), 42);
    chk("lat_error", int'(error), 0);
    step();
    chk("lat_valid_drop", int'(value_valid), 0);

    // Backpressure: value held while consumer stalls
    do_reset();
    value_ready = 1'b0;
    send_str("5.");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", int'(value_valid), 1);
      chk("bp_value", int'(value), 5);
      chk("bp_char_ready", int'(char_ready), 0);
      step();
    end
    value_ready = 1'b1;
    chk("bp_valid6", int'(value_valid), 1);
    step();
    chk("bp_valid_after", int'(value_valid), 0);
    chk("bp_char_ready_after", int'(char_ready), 1);

    // Error pulse is one cycle wide
    do_reset();
    send(8'h41);
    chk("err_pulse", int'(error), 1);
    step();
    chk("err_pulse_end", int'(error), 0);

    // Reset mid-number drops the partial value
    do_reset();
    send_str("99");
    rst = 1'b0;
    #1;
    chk("midrst_value", int'(value), 0);
    chk("midrst_valid", int'(value_valid), 0);
    chk("midrst_error", int'(error), 0);
    chk("midrst_char_ready", int'(char_ready), 1);
    step();
    rst = 1'b1;
    s0 = obs_vals.size();
    e0 = err_seen;
    send(8'h0D);
    repeat (3) step();
    chk("midrst_no_value", obs_vals.size() - s0, 0);
    chk("midrst_no_error", err_seen - e0, 0);

    // Randomized stream with random consumer backpressure
    do_reset();
    stream = {};
    s0 = obs_vals.size();
    e0 = err_seen;
    rnd_rdy = 1'b1;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) c = 8'h30 + 8'($urandom_range(0, 9));
      else if (r < 68) c = 8'h0D;
      else if (r < 78) c = 8'h20;
      else begin
        case ($urandom_range(0, 3))
          0: c = 8'h41;
          1: c = 8'h78;
          2: c = 8'h2F;
          default: c = 8'h3A;
        endcase
      end
      stream.push_back(c);
      repeat ($urandom_range(0, 2)) step();
      send(c);
    end
    rnd_rdy = 1'b0;
    value_ready = 1'b1;
    repeat (5) step();
    model();
    chk("rand_count", obs_vals.size() - s0, exp_vals.size());
    foreach (exp_vals[k]) begin
      if (s0 + k < obs_vals.size())
        chk($sformatf("rand_value%0d", k), obs_vals[s0 + k], exp_vals[k]);
    end
    chk("rand_errors", err_seen - e0, exp_errs);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
